// File: rtl/line_capture_ctrl_if.sv
// Line capture bus: single-port line_ram access plus the replay stream.
// master = capture controller, slave = line_ram and stream sink.
interface line_capture_ctrl_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 24
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  ram_wr_en;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output ram_addr,
    output ram_wr_data,
    output ram_wr_en,
    input  ram_rd_data,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_last
  );

  modport slave (
    input  ram_addr,
    input  ram_wr_data,
    input  ram_wr_en,
    output ram_rd_data,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_last
  );
endinterface

// File: rtl/line_capture_ctrl.sv
// Captures one video row into a single-port line RAM and replays it
// as a valid/ready stream through a 2-entry skid buffer.
module line_capture_ctrl #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 24,
  parameter int ROW_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vsync,
  input  logic                  de,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic [ROW_WIDTH-1:0]  cap_row,
  input  logic                  cap_start,
  input  logic                  rd_start,
  output logic                  busy,
  output logic                  line_ok,
  output logic [ADDR_WIDTH:0]   line_len,
  line_capture_ctrl_if.master   bus
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH = ONE << ADDR_WIDTH;
  localparam logic [ROW_WIDTH-1:0] RONE = ROW_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_WAIT_ROW,
    S_CAPTURE,
    S_READY,
    S_READOUT
  } state_e;

  state_e state_q, state_d;

  logic                  vsync_q, vsync_p_q;
  logic                  de_q, de_p_q;
  logic [DATA_WIDTH-1:0] pix_q;

  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [CW-1:0]         pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]         len_q, len_d;
  logic [CW-1:0]         rd_addr_q, rd_addr_d;
  logic                  pend_q, pend_d;
  logic                  pend_last_q, pend_last_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [DATA_WIDTH-1:0] buf_data_d [2];
  logic [1:0]            buf_last_q, buf_last_d;

  logic                  vs_rise, de_fall, pop;
  logic [1:0]            occ;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;

  always_comb begin
    vs_rise     = vsync_q & ~vsync_p_q;
    de_fall     = ~de_q & de_p_q;
    pop         = (cnt_q != 2'd0) & bus.out_ready;
    occ         = cnt_q + {1'b0, pend_q};
    state_d     = state_q;
    row_d       = row_q;
    pix_cnt_d   = pix_cnt_q;
    len_d       = len_q;
    rd_addr_d   = rd_addr_q;
    pend_d      = 1'b0;
    pend_last_d = 1'b0;
    cnt_d       = cnt_q;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    wr_en       = 1'b0;
    wr_addr     = '0;

    if (vs_rise) begin
      row_d = '0;
    end else if (de_fall && row_q != '1) begin
      row_d = row_q + RONE;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cap_start) begin
          state_d = S_WAIT_FRAME;
          len_d   = '0;
        end
      end
      S_WAIT_FRAME: begin
        if (vs_rise) state_d = S_WAIT_ROW;
      end
      S_WAIT_ROW: begin
        if (!vs_rise && de_q && row_q == cap_row) begin
          state_d   = S_CAPTURE;
          wr_en     = 1'b1;
          pix_cnt_d = ONE;
        end
      end
      S_CAPTURE: begin
        // a vsync rise mid-line closes the line like a de fall
        if (vs_rise || de_fall) begin
          state_d = S_READY;
          len_d   = pix_cnt_q;
        end else if (de_q && pix_cnt_q != DEPTH) begin
          wr_en     = 1'b1;
          wr_addr   = pix_cnt_q[ADDR_WIDTH-1:0];
          pix_cnt_d = pix_cnt_q + ONE;
        end
      end
      S_READY: begin
        if (cap_start) begin
          state_d = S_WAIT_FRAME;
          len_d   = '0;
        end else if (rd_start && len_q != '0) begin
          // address 0 is already on the bus here, so its read is in flight
          state_d     = S_READOUT;
          rd_addr_d   = ONE;
          pend_d      = 1'b1;
          pend_last_d = (len_q == ONE);
        end
      end
      S_READOUT: begin
        if (rd_addr_q != len_q &&
            (occ < 2'd2 || (occ == 2'd2 && pop))) begin
          rd_addr_d   = rd_addr_q + ONE;
          pend_d      = 1'b1;
          pend_last_d = (rd_addr_q == len_q - ONE);
        end
        if (pop && buf_last_q[0]) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      buf_data_d[0] = buf_data_q[1];
      buf_last_d[0] = buf_last_q[1];
      cnt_d         = cnt_q - 2'd1;
    end
    if (pend_q) begin
      if (cnt_d == 2'd0) begin
        buf_data_d[0] = bus.ram_rd_data;
        buf_last_d[0] = pend_last_q;
      end else begin
        buf_data_d[1] = bus.ram_rd_data;
        buf_last_d[1] = pend_last_q;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b0;
      vsync_p_q   <= 1'b0;
      de_q        <= 1'b0;
      de_p_q      <= 1'b0;
      pix_q       <= '0;
      row_q       <= '0;
      pix_cnt_q   <= '0;
      len_q       <= '0;
      rd_addr_q   <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      cnt_q       <= '0;
      buf_data_q  <= '{default: '0};
      buf_last_q  <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= vsync;
      vsync_p_q   <= vsync_q;
      de_q        <= de;
      de_p_q      <= de_q;
      pix_q       <= pix_data;
      row_q       <= row_d;
      pix_cnt_q   <= pix_cnt_d;
      len_q       <= len_d;
      rd_addr_q   <= rd_addr_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
      cnt_q       <= cnt_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
    end
  end

  assign busy = (state_q == S_WAIT_FRAME) || (state_q == S_WAIT_ROW) ||
                (state_q == S_CAPTURE) || (state_q == S_READOUT);
  assign line_ok  = (state_q == S_READY) || (state_q == S_READOUT);
  assign line_len = len_q;

  assign bus.ram_wr_en   = wr_en;
  assign bus.ram_wr_data = wr_en ? pix_q : '0;
  assign bus.ram_addr    = (state_q == S_READOUT) ?
                           rd_addr_q[ADDR_WIDTH-1:0] : wr_addr;

  assign bus.out_valid = (cnt_q != 2'd0);
  assign bus.out_data  = bus.out_valid ? buf_data_q[0] : '0;
  assign bus.out_last  = bus.out_valid & buf_last_q[0];
endmodule

// File: tb/tb_line_capture_ctrl.sv
// Scoreboard bench for line_capture_ctrl: expected RAM writes and
// replay beats are queued by stimulus and popped by a monitor.
module tb_line_capture_ctrl;
  localparam int AW = 11;
  localparam int DW = 24;
  localparam int RW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vsync = 1'b0;
  logic          de = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic [RW-1:0] cap_row = '0;
  logic          cap_start = 1'b0;
  logic          rd_start = 1'b0;
  logic          busy, line_ok;
  logic [AW:0]   line_len;
  bit            rand_mode = 1'b0;

  line_capture_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  line_capture_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROW_WIDTH(RW)
  ) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .de(de),
    .pix_data(pix_data), .cap_row(cap_row),
    .cap_start(cap_start), .rd_start(rd_start),
    .busy(busy), .line_ok(line_ok), .line_len(line_len),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) begin
    if (bus.ram_wr_en) mem[bus.ram_addr] <= bus.ram_wr_data;
    bus.ram_rd_data <= mem[bus.ram_addr];
  end

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_wr [$];
  logic [DW:0]   exp_beat [$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            beats_seen = 0;
  int            wr_seen = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int f, input int r,
                                        input int c);
    return {4'(f), 4'(r), 16'(c)};
  endfunction

  // monitor
  bit          stall_p = 1'b0;
  logic [DW:0] stall_v = '0;
  always @(negedge clk) begin
    wr_t         w;
    logic [DW:0] b;
    if (stall_p)
      check("stall_hold",
            64'({bus.out_valid, bus.out_last, bus.out_data}),
            64'({1'b1, stall_v}));
    if (bus.ram_wr_en === 1'b1) begin
      wr_seen++;
      if (exp_wr.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL ram_write: got addr %0d data %0h expected none",
                 bus.ram_addr, bus.ram_wr_data);
      end else begin
        w = exp_wr.pop_front();
        check("ram_write", 64'({bus.ram_addr, bus.ram_wr_data}),
              64'(w));
      end
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      beats_seen++;
      if (exp_beat.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL beat: got %0h expected none",
                 {bus.out_last, bus.out_data});
      end else begin
        b = exp_beat.pop_front();
        check("beat", 64'({bus.out_last, bus.out_data}), 64'(b));
      end
    end
    stall_p = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
    stall_v = {bus.out_last, bus.out_data};
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_ctrl"},
          64'({busy, line_ok, line_len, bus.ram_wr_en, bus.ram_addr}),
          64'd0);
    check({name, "_data"},
          64'({bus.ram_wr_data, bus.out_valid, bus.out_last,
               bus.out_data}),
          64'd0);
  endtask

  task automatic send_frame(input int f, input int rows, input int npix,
                            input int tgt, input int arm_after,
                            input int rst_col);
    vsync = 1'b1;
    tick(); tick();
    vsync = 1'b0;
    repeat (3) tick();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < npix; c++) begin
        de = 1'b1;
        pix_data = pix(f, r, c);
        if (r == tgt && c == rst_col) rst = 1'b1;
        if (r == tgt && c < 2**AW && (rst_col < 0 || c < rst_col))
          exp_wr.push_back('{addr: AW'(c), data: pix(f, r, c)});
        tick();
        if (rst) begin
          rst = 1'b0;
          check_idle("rst_capture");
        end
      end
      de = 1'b0;
      pix_data = '0;
      if (r == arm_after) cap_start = 1'b1;
      tick();
      cap_start = 1'b0;
      repeat (4) tick();
    end
  endtask

  task automatic replay(input int f, input int r, input int len,
                        input bit chk_lat, input int rst_beat);
    int base;
    int k;
    base = beats_seen;
    for (int i = 0; i < len; i++)
      exp_beat.push_back({1'(i == len - 1), pix(f, r, i)});
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    if (chk_lat) check("valid_cycle1", 64'(bus.out_valid), 64'd0);
    tick();
    if (chk_lat) check("valid_cycle2", 64'(bus.out_valid), 64'd1);
    if (rst_beat >= 0) begin
      k = 0;
      while (beats_seen != base + rst_beat && k < 2000) begin
        @(negedge clk); #1;
        k++;
      end
      check("rst_beat_reached", 64'(beats_seen - base), 64'(rst_beat));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle("rst_readout");
      exp_beat.delete();
    end else begin
      k = 0;
      while (!(line_ok && !busy) && k < 10000) begin
        tick();
        k++;
      end
      check("readout_done", 64'({line_ok, busy}), 64'b10);
      check("beats_left", 64'(exp_beat.size()), 64'd0);
      check("beat_count", 64'(beats_seen - base), 64'(len));
    end
  endtask

  task automatic arm(input int row);
    cap_row = RW'(row);
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    check("armed", 64'({busy, line_ok, line_len}), 64'({2'b10, 12'd0}));
  endtask

  task automatic check_line(input int len);
    repeat (5) tick();
    check("line_len", 64'(line_len), 64'(len));
    check("line_ok", 64'({line_ok, busy}), 64'b10);
    check("writes_left", 64'(exp_wr.size()), 64'd0);
  endtask

  initial begin
    int w0;
    rst = 1'b1;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("idle");

    arm(2);
    send_frame(1, 3, 640, 2, -1, -1);
    check_line(640);

    replay(1, 2, 640, 1'b1, -1);
    replay(1, 2, 640, 1'b1, -1);

    rand_mode = 1'b1;
    replay(1, 2, 640, 1'b0, -1);
    rand_mode = 1'b0;
    tick();

    arm(0);
    send_frame(2, 1, 2100, 0, -1, -1);
    check_line(2048);
    replay(2, 0, 2048, 1'b1, -1);

    cap_row = RW'(2);
    w0 = wr_seen;
    send_frame(3, 4, 300, -1, 0, -1);
    check("midframe_no_write", 64'(wr_seen - w0), 64'd0);
    check("midframe_wait", 64'({busy, line_ok}), 64'b10);
    send_frame(4, 3, 300, 2, -1, -1);
    check_line(300);
    replay(4, 2, 300, 1'b1, -1);

    arm(1);
    send_frame(5, 3, 300, 1, -1, 100);
    tick();
    check_idle("after_rst_capture");

    arm(1);
    send_frame(6, 3, 64, 1, -1, -1);
    check_line(64);
    replay(6, 1, 64, 1'b0, 10);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    repeat (3) tick();
    check_idle("rd_start_in_idle");
    check("queues_empty", 64'(exp_wr.size() + exp_beat.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
